// File: rtl/register_file_pkg.sv
// Shared sizing constants for the datapath register file.
package register_file_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DEPTH  = 1 << RF_ADDR_W;

endpackage

// File: rtl/register_file_reg_cell.sv
// One storage word with async active-low clear and a synchronous write enable.
module register_file_reg_cell #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              elk,
  input  logic              nrst,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (we) data_d = d;
  end

  always_ff @(posedge elk or negedge nrst) begin
    if (!nrst) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port, R0 fixed at zero.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DEPTH  = RF_DEPTH
) (
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addrA,
  input  logic [ADDR_W-1:0] rd_addrB,
  output logic [DATA_W-1:0] rd_dataA,
  output logic [DATA_W-1:0] rd_dataB,
  input  logic              elk,
  input  logic              nrst
);

  logic              wr_en_valid;
  logic [DEPTH-1:1]  we_vec;
  logic [DATA_W-1:0] regs [DEPTH];

  // An unknown enable must never be taken as a write.
  assign wr_en_valid = (wr_en === 1'b1);

  always_comb begin
    we_vec = '0;
    for (int i = 1; i < DEPTH; i++) begin
      we_vec[i] = wr_en_valid && (wr_addr == ADDR_W'(i));
    end
  end

  assign regs[0] = '0;

  for (genvar g = 1; g < DEPTH; g++) begin : g_cell
    register_file_reg_cell #(.DATA_W(DATA_W)) u_cell (
      .elk  (elk),
      .nrst (nrst),
      .we   (we_vec[g]),
      .d    (wr_data),
      .q    (regs[g])
    );
  end

  assign rd_dataA = regs[rd_addrA];
  assign rd_dataB = regs[rd_addrB];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file against an array reference model.
module tb_register_file;

  logic        elk;
  logic        nrst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addrA;
  logic [4:0]  rd_addrB;
  logic [31:0] rd_dataA;
  logic [31:0] rd_dataB;

  logic [31:0] mdl [32];
  int n_tests = 0;
  int n_fail  = 0;

  register_file #(.DATA_W(32), .ADDR_W(5), .DEPTH(32)) dut (
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addrA (rd_addrA),
    .rd_addrB (rd_addrB),
    .rd_dataA (rd_dataA),
    .rd_dataB (rd_dataB),
    .elk      (elk),
    .nrst     (nrst)
  );

  initial elk = 1'b0;
  always #5 elk = ~elk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
  endtask

  task automatic mdl_write(input logic en, input logic [4:0] a, input logic [31:0] d);
    if (en === 1'b1 && a != 5'd0) mdl[a] = d;
  endtask

  // Drive at the falling edge, commit at the rising edge, settle 1 time unit.
  task automatic do_write(input logic en, input logic [4:0] a, input logic [31:0] d);
    @(negedge elk);
    wr_en = en; wr_addr = a; wr_data = d;
    @(posedge elk);
    #1;
    mdl_write(en, a, d);
    wr_en = 1'b0;
  endtask

  task automatic read_pair(input logic [4:0] a, input logic [4:0] b, input string tag);
    rd_addrA = a; rd_addrB = b;
    #1;
    check({tag, "_A"}, rd_dataA, mdl[a]);
    check({tag, "_B"}, rd_dataB, mdl[b]);
  endtask

  initial begin
    logic [4:0]  ra, rb, wa;
    logic [31:0] wd;
    logic        we;

    nrst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addrA = 5'd8; rd_addrB = 5'd31;
    mdl_clear();
    #12;
    check("reset_A", rd_dataA, 32'd0);
    check("reset_B", rd_dataB, 32'd0);
    @(negedge elk);
    nrst = 1'b1;

    do_write(1'b1, 5'd8, 32'd11425652);
    rd_addrA = 5'd8; #1;
    check("wr_rd_A_R8", rd_dataA, 32'd11425652);

    do_write(1'b1, 5'd9, 32'd11425653);
    rd_addrB = 5'd9; #1;
    check("wr_rd_B_R9", rd_dataB, 32'd11425653);
    check("R8_kept", rd_dataA, 32'd11425652);

    rd_addrA = 5'd9; #1;
    check("same_addr_A", rd_dataA, 32'd11425653);
    check("same_addr_B", rd_dataB, 32'd11425653);
    rd_addrA = 5'd8;

    // Mid-cycle reset: outputs must clear before the next rising edge.
    @(posedge elk); #2;
    nrst = 1'b0; #1;
    mdl_clear();
    check("async_rst_R8", rd_dataA, 32'd0);
    check("async_rst_R9", rd_dataB, 32'd0);

    // Write attempted while reset is held must be blocked.
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hCAFEF00D;
    @(posedge elk); #1;
    check("rst_blocks_wr", rd_dataA, 32'd0);
    @(negedge elk);
    wr_en = 1'b0; nrst = 1'b1;

    do_write(1'b1, 5'd0, 32'hDEADBEEF);
    read_pair(5'd0, 5'd0, "R0_write");
    check("R0_const", rd_dataA, 32'd0);

    do_write(1'b0, 5'd5, 32'h00001234);
    read_pair(5'd5, 5'd5, "R5_en0");
    check("R5_en0_const", rd_dataA, 32'd0);

    do_write(1'bx, 5'd6, 32'h66666666);
    read_pair(5'd6, 5'd6, "R6_enX");

    // No bypass: old value before the edge, new value after it.
    do_write(1'b1, 5'd3, 32'h11111111);
    @(negedge elk);
    rd_addrA = 5'd3;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAAAA5555;
    #1;
    check("nobypass_pre", rd_dataA, 32'h11111111);
    @(posedge elk); #1;
    wr_en = 1'b0;
    check("nobypass_post", rd_dataA, 32'hAAAA5555);
    mdl_write(1'b1, 5'd3, 32'hAAAA5555);

    for (int i = 1; i < 32; i++) do_write(1'b1, 5'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 32; i++) begin
      read_pair(5'(i), 5'(31 - i), "sweep");
      check("sweep_arith", rd_dataA, 32'(i) * 32'h01010101);
    end

    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      ra = ($urandom_range(0, 1) == 1) ? wa : 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      @(negedge elk);
      wr_en = we; wr_addr = wa; wr_data = wd;
      rd_addrA = ra; rd_addrB = rb;
      #1;
      check("rand_pre_A", rd_dataA, mdl[ra]);
      check("rand_pre_B", rd_dataB, mdl[rb]);
      @(posedge elk); #1;
      mdl_write(we, wa, wd);
      check("rand_post_A", rd_dataA, mdl[ra]);
      check("rand_post_B", rd_dataB, mdl[rb]);
    end
    wr_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
